dig_scan_ctrl: RTL and testbench
================================

# dig_scan_ctrl

Parametrised multiplexed seven-segment digit scanner, the next generation of the fixed 8-digit scan counter. Sits between the system clock and the board's digit-select lines: a prescaler sets the slot period, a scan index walks only the enabled digits, and a blanking interval at the start of each slot removes ghosting. The segment-data mux downstream uses `dig_id` to pick the value for the active digit.

## Interface
- `N_DIG`, 8: number of digits scanned; legal range 2..16.
- `DIV`, 100000: clk cycles per digit slot; must be at least 2.
- `BLANK`, 2: dark cycles at the start of each slot; legal range 0..DIV-1.
- `SEL_ACTIVE_LOW`, 1: 1 = active select bit is 0, inactive is 1; 0 = opposite polarity.
- `IDW`: derived, max(1, clog2(N_DIG)); not overridable.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; when low, scanning freezes and the display goes dark.
- `dig_mask`  in  N_DIG  per-digit enable; bit i = 1 means digit i takes part in the scan.
- `dig_id`  out  IDW  index of the current digit slot (registered).
- `dig_sel`  out  N_DIG  one-hot digit select, polarity set by SEL_ACTIVE_LOW (registered).
- `dig_blank`  out  1  high whenever all selects are inactive (registered).
- `frame_start`  out  1  one-cycle pulse when the scan wraps to a new frame (registered).

## Operation
- Prescaler `cnt` runs 0..DIV-1 and advances only when `en`=1. A step happens on the edge where `cnt`=DIV-1 and `en`=1; on that edge `cnt` returns to 0.
- On a step, `dig_id` moves to the next index above the current one whose `dig_mask` bit is 1, searching upward and wrapping modulo N_DIG. The mask value used is the one sampled at that edge.
  - If only the current digit is enabled, `dig_id` stays where it is.
  - If `dig_mask` is all zero, `dig_id` holds.
- `frame_start`=1 for one cycle after any step whose new index is less than or equal to the old index. With a single enabled digit, this means every step.
- Select gating: after each edge, `dig_sel` drives the active level on bit `dig_id` only if all of the following hold at that edge:
  - `en`=1
  - new `cnt` ≥ BLANK
  - `dig_mask[new dig_id]`=1

  Otherwise every bit of `dig_sel` is inactive.
- `dig_blank` is the inverse of "any select active".
- When `en` is low, `cnt` and `dig_id` hold, all selects go inactive, and `dig_blank`=1. On the first edge with `en`=1, counting resumes from the held `cnt`.
- A `dig_mask` change inside a slot:
  - The current digit is gated off on the next edge if its bit clears.
  - The search for the next digit uses the mask present at the step edge.
- Out-of-range indices (N_DIG not a power of 2) are never produced.

## Timing
- Reset (asynchronous, `rst`=0) forces:
  - `cnt`=0, `dig_id`=0, `frame_start`=0
  - `dig_sel` all inactive (all ones when SEL_ACTIVE_LOW=1)
  - `dig_blank`=1

  These values hold while `rst`=0. Reset asserted mid-slot takes effect immediately, without waiting for a clock edge.
- Slot length is exactly DIV cycles; the first BLANK cycles of each slot have all selects inactive.
- First slot after reset release: digit 0 lights at the first edge where `cnt` reaches BLANK. With BLANK=0, that is the first edge, provided mask bit 0 = 1.
- `dig_id`, `dig_sel`, `dig_blank` and `frame_start` change on the same edge; there is no skew between them.
- Full frame period equals DIV × (number of set mask bits), or DIV cycles when the mask is all zero.

## Test plan
- Basic scan (N_DIG=4, DIV=4, BLANK=1, mask=1111, en=1 from reset release):
  - `dig_id` sequence is 0,1,2,3,0 with 4 cycles per slot.
  - `dig_sel` pattern per slot is 1111, 1110, 1110, 1110, then 1111, 1101, …
  - `frame_start` pulses on the 3→0 step.
- Skip masked digits (mask=1010, same parameters):
  - `dig_id` alternates 1,3,1,3; digits 0 and 2 are never selected.
  - `frame_start` pulses on each 3→1 step.
  - The slot immediately after reset (`dig_id`=0, masked) stays dark.
- Edge masks:
  - mask=0000: `dig_blank` stays 1, `dig_id` holds, `frame_start` never pulses.
  - mask=0100: `dig_id` steps to 2 and then stays 2, with `frame_start` on every step.
- Enable freeze: drop `en` for 5 cycles mid-slot at `cnt`=2.
  - All selects go inactive on the next edge; `cnt` and `dig_id` hold.
  - After `en` returns, the slot finishes in exactly DIV−2 more cycles.
- Asynchronous reset mid-slot: assert `rst`=0 between clock edges while digit 2 is lit.
  - Outputs go to their reset values immediately.
  - After release, the scan restarts at digit 0 with the full blank interval.
- Polarity and width: with N_DIG=6, SEL_ACTIVE_LOW=0, BLANK=0, DIV=2, mask=111111:
  - `dig_id` runs 0..5 and wraps to 0, never reaching 6 or 7.
  - `dig_sel` is active-high one-hot (e.g. 000001 for digit 0).

Source files
------------

// File: rtl/dig_scan_ctrl.sv
// Multiplexed seven-segment digit scanner: prescaled slot timing, masked digit walk,
// per-slot blanking and frame-wrap pulse, all outputs registered.
module dig_scan_ctrl #(
  parameter int unsigned N_DIG          = 8,
  parameter int unsigned DIV            = 100000,
  parameter int unsigned BLANK          = 2,
  parameter int unsigned SEL_ACTIVE_LOW = 1,
  localparam int unsigned IDW           = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_DIG-1:0] dig_mask,
  output logic [IDW-1:0]   dig_id,
  output logic [N_DIG-1:0] dig_sel,
  output logic             dig_blank,
  output logic             frame_start
);

  localparam int unsigned     CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic [N_DIG-1:0] SEL_OFF = {N_DIG{SEL_ACTIVE_LOW != 0}};

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic [IDW-1:0]   id_d;
  logic [IDW-1:0]   nxt_id;
  logic             found;
  logic             fs_d;
  logic             lit_d;
  logic [N_DIG-1:0] sel_d;

  // Nearest enabled digit above the current one, wrapping; offset N_DIG is the current digit.
  always_comb begin : next_id_search
    int j;
    j      = 0;
    found  = 1'b0;
    nxt_id = dig_id;
    for (int k = int'(N_DIG); k >= 1; k--) begin
      j = int'(dig_id) + k;
      if (j >= int'(N_DIG)) j = j - int'(N_DIG);
      if (dig_mask[j]) begin
        found  = 1'b1;
        nxt_id = IDW'(j);
      end
    end
  end

  // Next prescaler/index state and gated select pattern.
  always_comb begin
    cnt_d = cnt;
    id_d  = dig_id;
    fs_d  = 1'b0;
    if (en) begin
      if (cnt == CNT_LAST) begin
        cnt_d = '0;
        if (found) begin
          id_d = nxt_id;
          fs_d = (nxt_id <= dig_id);
        end
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end
    lit_d = en && (int'(cnt_d) >= int'(BLANK)) && dig_mask[id_d];
    sel_d = lit_d ? ((N_DIG'(1) << id_d) ^ SEL_OFF) : SEL_OFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      dig_id      <= '0;
      dig_sel     <= SEL_OFF;
      dig_blank   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      dig_id      <= id_d;
      dig_sel     <= sel_d;
      dig_blank   <= !lit_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_dig_scan_ctrl.sv
// Bench for dig_scan_ctrl: two parameterisations, behavioural reference model feeding
// an expected-value queue that is drained against the registered outputs each cycle.
module tb_dig_scan_ctrl;

  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] sel;
    logic        blank;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a;
  logic [3:0] mask_a;
  logic [1:0] id_a;
  logic [3:0] sel_a;
  logic       blank_a, fs_a;

  logic       rst_b, en_b;
  logic [5:0] mask_b;
  logic [2:0] id_b;
  logic [5:0] sel_b;
  logic       blank_b, fs_b;

  dig_scan_ctrl #(.N_DIG(4), .DIV(4), .BLANK(1), .SEL_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .dig_mask(mask_a),
    .dig_id(id_a), .dig_sel(sel_a), .dig_blank(blank_a), .frame_start(fs_a)
  );

  dig_scan_ctrl #(.N_DIG(6), .DIV(2), .BLANK(0), .SEL_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .dig_mask(mask_b),
    .dig_id(id_b), .dig_sel(sel_b), .dig_blank(blank_b), .frame_start(fs_b)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   ma_cnt, ma_id, mb_cnt, mb_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge.
  task automatic model_step(input int n, input int div, input int blank, input bit low,
                            input logic en, input logic [15:0] mask,
                            inout int cnt, inout int id, output exp_t x);
    logic [15:0] oh;
    logic [15:0] nm;
    bit          lit;
    x  = '0;
    nm = 16'((32'd1 << n) - 1);
    if (en) begin
      if (cnt == div - 1) begin
        cnt = 0;
        for (int k = 1; k <= n; k++) begin
          int j;
          j = (id + k) % n;
          if (mask[j]) begin
            x.fs = (j <= id);
            id   = j;
            break;
          end
        end
      end else begin
        cnt++;
      end
    end
    lit = en && (cnt >= blank) && mask[id];
    oh  = '0;
    oh[id] = 1'b1;
    x.sel   = (lit ? oh : 16'h0) ^ (low ? nm : 16'h0);
    x.id    = 4'(id);
    x.blank = !lit;
  endtask

  task automatic cyc_a(input logic e, input logic [3:0] m);
    exp_t x;
    en_a   = e;
    mask_a = m;
    model_step(4, 4, 1, 1'b1, e, {12'h0, m}, ma_cnt, ma_id, x);
    qa.push_back(x);
    @(posedge clk);
    #1;
    if (qa.size() == 0) begin
      chk("a_sb_empty", 32'(qa.size()), 32'd1);
    end else begin
      x = qa.pop_front();
      chk("a_id", 32'(id_a), 32'(x.id));
      chk("a_sel", 32'(sel_a), 32'(x.sel));
      chk("a_blank", 32'(blank_a), 32'(x.blank));
      chk("a_fs", 32'(fs_a), 32'(x.fs));
    end
  endtask

  task automatic cyc_b(input logic e, input logic [5:0] m);
    exp_t x;
    en_b   = e;
    mask_b = m;
    model_step(6, 2, 0, 1'b0, e, {10'h0, m}, mb_cnt, mb_id, x);
    qb.push_back(x);
    @(posedge clk);
    #1;
    if (qb.size() == 0) begin
      chk("b_sb_empty", 32'(qb.size()), 32'd1);
    end else begin
      x = qb.pop_front();
      chk("b_id", 32'(id_b), 32'(x.id));
      chk("b_sel", 32'(sel_b), 32'(x.sel));
      chk("b_blank", 32'(blank_b), 32'(x.blank));
      chk("b_fs", 32'(fs_b), 32'(x.fs));
      chk("b_id_range", 32'(id_b < 3'd6), 32'd1);
    end
  endtask

  // Async assert between edges, immediate check, hold across one edge, then release.
  task automatic reset_a();
    rst_a = 1'b0;
    #1;
    ma_cnt = 0;
    ma_id  = 0;
    qa.delete();
    chk("a_rst_sel", 32'(sel_a), 32'h0000000F);
    chk("a_rst_id", 32'(id_a), 32'd0);
    chk("a_rst_blank", 32'(blank_a), 32'd1);
    chk("a_rst_fs", 32'(fs_a), 32'd0);
    @(posedge clk);
    #1;
    chk("a_rst_hold_sel", 32'(sel_a), 32'h0000000F);
    rst_a = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; en_a = 1'b1; mask_a = 4'hF;
    rst_b = 1'b1; en_b = 1'b1; mask_b = 6'h3F;
    #2;
    rst_b = 1'b0;

    // Basic scan, all digits enabled
    reset_a();
    for (int c = 1; c <= 20; c++) begin
      cyc_a(1'b1, 4'b1111);
      if (c == 1)  chk("basic_first_lit", 32'(sel_a), 32'b1110);
      if (c == 5)  chk("basic_slot1_sel", 32'(sel_a), 32'b1101);
      if (c == 16) chk("basic_wrap_fs", 32'(fs_a), 32'd1);
    end

    // Masked digits skipped
    reset_a();
    for (int c = 1; c <= 20; c++) begin
      cyc_a(1'b1, 4'b1010);
      if (c == 1)  chk("skip_dark_slot0", 32'(blank_a), 32'd1);
      if (c == 5)  chk("skip_sel_d1", 32'(sel_a), 32'b1101);
      if (c == 12) chk("skip_wrap_fs", 32'(fs_a), 32'd1);
    end

    // All-zero mask
    reset_a();
    for (int c = 1; c <= 12; c++) cyc_a(1'b1, 4'b0000);
    chk("zero_mask_id", 32'(id_a), 32'd0);
    chk("zero_mask_blank", 32'(blank_a), 32'd1);

    // Single enabled digit
    reset_a();
    for (int c = 1; c <= 16; c++) begin
      cyc_a(1'b1, 4'b0100);
      if (c == 8) chk("single_fs", 32'(fs_a), 32'd1);
    end
    chk("single_id", 32'(id_a), 32'd2);

    // Enable freeze mid-slot at cnt=2
    reset_a();
    for (int c = 1; c <= 6; c++) cyc_a(1'b1, 4'b1111);
    for (int c = 1; c <= 5; c++) begin
      cyc_a(1'b0, 4'b1111);
      if (c == 1) chk("freeze_dark", 32'(sel_a), 32'b1111);
    end
    for (int c = 1; c <= 10; c++) begin
      cyc_a(1'b1, 4'b1111);
      if (c == 2) chk("freeze_resume_step", 32'(id_a), 32'd2);
    end

    // Async reset while digit 2 lit
    reset_a();
    for (int c = 1; c <= 9; c++) cyc_a(1'b1, 4'b1111);
    chk("pre_rst_sel", 32'(sel_a), 32'b1011);
    #3;
    reset_a();
    for (int c = 1; c <= 10; c++) begin
      cyc_a(1'b1, 4'b1111);
      if (c == 1) chk("post_rst_d0", 32'(sel_a), 32'b1110);
    end

    // Random enable and mid-slot mask changes
    reset_a();
    for (int c = 1; c <= 60; c++) begin
      logic [3:0] m;
      logic       e;
      m = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 7) != 0);
      cyc_a(e, m);
    end

    // Active-high, non-power-of-two digit count
    rst_a = 1'b0;
    mb_cnt = 0;
    mb_id  = 0;
    qb.delete();
    #1;
    chk("b_rst_sel", 32'(sel_b), 32'd0);
    rst_b = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      cyc_b(1'b1, 6'b111111);
      if (c == 1) chk("b_first_sel", 32'(sel_b), 32'b000001);
      if (c == 12) chk("b_wrap_fs", 32'(fs_b), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
